do_unpad_serializer: RTL and testbench



---
 rtl/romulus_config_pkg.sv | 24 ++
 rtl/do_unpad_serializer_lane_mask.sv | 19 +
 rtl/do_unpad_serializer.sv | 108 ++++++++++
 tb/tb_do_unpad_serializer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/romulus_config_pkg.sv
// Shared Romulus datapath configuration: bus/block geometry, FSM state type
// and the beat-count helper used by the output serializer.
package romulus_config_pkg;

  localparam int BUSW     = 32;
  localparam int LANES    = BUSW / 8;
  localparam int BUSSHIFT = 2;
  localparam int CNTW     = 2;
  localparam int BLKW     = 128;
  localparam int BEATS    = 16 / LANES;

  typedef enum logic {
    IDLE,
    SEND
  } unpad_state_t;

  // A partial segment needs ceil(seglen/LANES) beats; a full block needs all of them.
  function automatic logic [CNTW:0] calc_beats(input logic pad, input logic [3:0] seglen);
    logic [4:0] sum;
    sum = {1'b0, seglen} + 5'd3;
    return pad ? (CNTW+1)'(sum >> BUSSHIFT) : (CNTW+1)'(BEATS);
  endfunction

endpackage

// File: rtl/do_unpad_serializer_lane_mask.sv
// Decodes which byte lanes of the current beat carry real block bytes and
// which are padding that must be blanked before leaving the core.
module unpad_lane_mask
  import romulus_config_pkg::*;
(
  input  logic [3:0]       seglen,
  input  logic [CNTW-1:0]  cnt,
  input  logic             pad,
  output logic [LANES-1:0] keep
);

  always_comb begin
    keep = '0;
    for (int i = 0; i < LANES; i++) begin
      keep[i] = !pad || ((LANES * int'(cnt) + i) < int'(seglen));
    end
  end

endmodule

// File: rtl/do_unpad_serializer.sv
// Serializes one captured 128-bit block onto the DO bus, stripping padding
// bytes from a partial final segment (zero fill, or rdi fill for masked shares).
module do_unpad_serializer
  import romulus_config_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [BLKW-1:0] blk_data,
  input  logic            blk_valid,
  output logic            blk_ready,
  input  logic [3:0]      seglen,
  input  logic            pad,
  input  logic            last,
  input  logic            share,
  input  logic [BUSW-1:0] rdi,
  output logic [BUSW-1:0] do_data,
  output logic            do_valid,
  input  logic            do_ready,
  output logic            do_last
);

  unpad_state_t    state, state_next;
  logic [CNTW-1:0] cnt, cnt_next;
  logic            capture;

  logic [BLKW-1:0] data_r;
  logic [3:0]      seglen_r;
  logic            pad_r, last_r, share_r;

  logic [CNTW:0]   beats_in, beats_r;
  logic            last_beat;
  logic [LANES-1:0] keep;
  logic [BUSW-1:0] word;

  assign beats_in  = calc_beats(pad, seglen);
  assign beats_r   = calc_beats(pad_r, seglen_r);
  assign last_beat = ({1'b0, cnt} == beats_r - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_r   <= '0;
      seglen_r <= '0;
      pad_r    <= 1'b0;
      last_r   <= 1'b0;
      share_r  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        data_r   <= blk_data;
        seglen_r <= seglen;
        pad_r    <= pad;
        last_r   <= last;
        share_r  <= share;
      end
    end
  end

  // An empty partial segment is consumed in IDLE without emitting any beat.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (blk_valid) begin
          capture = 1'b1;
          if (beats_in != '0) begin
            cnt_next   = '0;
            state_next = SEND;
          end
        end
      end
      SEND: begin
        if (do_ready) begin
          if (last_beat) state_next = IDLE;
          else           cnt_next   = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  unpad_lane_mask u_lane_mask (
    .seglen (seglen_r),
    .cnt    (cnt),
    .pad    (pad_r),
    .keep   (keep)
  );

  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (keep[i])
        word[BUSW-1-8*i -: 8] = data_r[BLKW-1-8*(LANES*int'(cnt)+i) -: 8];
      else if (share_r)
        word[BUSW-1-8*i -: 8] = rdi[BUSW-1-8*i -: 8];
    end
  end

  assign blk_ready = (state == IDLE) && !rst;
  assign do_valid  = (state == SEND);
  assign do_data   = do_valid ? word : '0;
  assign do_last   = do_valid && last_r && last_beat;

endmodule

// File: tb/tb_do_unpad_serializer.sv
// Scoreboard bench for do_unpad_serializer: expected beats are queued when a
// block is offered and compared on each DO handshake.
module tb_do_unpad_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [3:0]   seglen;
  logic         pad;
  logic         last;
  logic         share;
  logic [31:0]  rdi;
  logic [31:0]  do_data;
  logic         do_valid;
  logic         do_ready;
  logic         do_last;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic        hold_pending = 1'b0;
  logic [31:0] held_data;
  logic        rdi_vary = 1'b0;

  localparam logic [127:0] DATA_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DATA_B = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  localparam logic [127:0] DATA_C = 128'hCAFEF00D_13579BDF_2468ACE0_0F1E2D3C;

  always #5 clk = ~clk;

  do_unpad_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .seglen    (seglen),
    .pad       (pad),
    .last      (last),
    .share     (share),
    .rdi       (rdi),
    .do_data   (do_data),
    .do_valid  (do_valid),
    .do_ready  (do_ready),
    .do_last   (do_last)
  );

  function automatic logic [31:0] exp_beat(input logic [127:0] d, input int sl, input logic p,
                                           input logic sh, input logic [31:0] r, input int beat);
    logic [31:0] w;
    int b;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      b = 4 * beat + i;
      if (!p || b < sl) w[31-8*i -: 8] = d[127-8*b -: 8];
      else if (sh)      w[31-8*i -: 8] = r[31-8*i -: 8];
      else              w[31-8*i -: 8] = 8'h00;
    end
    return w;
  endfunction

  // Handshake monitor: sampled on the falling edge, between input changes and the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (do_valid) begin
        tests++;
        if (blk_ready !== 1'b0) begin
          fails++;
          $display("[TB] FAIL overlap: blk_ready=%b while do_valid, required 0", blk_ready);
        end
      end
      if (hold_pending && do_valid && !rdi_vary) begin
        tests++;
        if (do_data !== held_data) begin
          fails++;
          $display("[TB] FAIL hold_stable: do_data=%h, required %h", do_data, held_data);
        end
      end
      if (do_valid && do_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL extra_beat: do_data=%h, required no beat", do_data);
        end else begin
          e = sb.pop_front();
          if (do_data !== e.data || do_last !== e.last) begin
            fails++;
            $display("[TB] FAIL beat: do_data=%h do_last=%b, required %h last=%b",
                     do_data, do_last, e.data, e.last);
          end
        end
      end
      hold_pending = do_valid && !do_ready;
      held_data    = do_data;
    end
  end

  task automatic send_block(input logic [127:0] d, input logic [3:0] sl, input logic p,
                            input logic l, input logic sh, input logic [31:0] model_rdi,
                            output int waited);
    int   nb;
    exp_t e;
    nb = p ? (int'(sl) + 3) / 4 : 4;
    for (int k = 0; k < nb; k++) begin
      e.data = exp_beat(d, int'(sl), p, sh, model_rdi, k);
      e.last = l && (k == nb - 1);
      sb.push_back(e);
    end
    blk_data  = d;
    seglen    = sl;
    pad       = p;
    last      = l;
    share     = sh;
    blk_valid = 1'b1;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (blk_ready) break;
      waited++;
      if (waited > 100) begin
        tests++;
        fails++;
        $display("[TB] FAIL accept_timeout: blk_ready=%b, required 1", blk_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !do_valid) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("[TB] FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; seglen = '0; pad = 1'b0;
    last = 1'b0; share = 1'b0; rdi = '0; do_ready = 1'b0;
    #1;
    tests++;
    if (do_valid !== 1'b0 || do_last !== 1'b0 || do_data !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: valid=%b last=%b data=%h, required 0 0 0",
               do_valid, do_last, do_data);
    end
    tests++;
    if (blk_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_blk_ready: %b, required 0", blk_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (blk_ready !== 1'b1 || do_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: blk_ready=%b do_valid=%b, required 1 0",
               blk_ready, do_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_block();
    int w;
    do_ready = 1'b1;
    send_block(DATA_A, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, w);
    tests++;
    if (do_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL first_beat_latency: do_valid=%b, required 1", do_valid);
    end
    drain();
  endtask

  task automatic test_partial();
    int w;
    do_ready = 1'b1;
    send_block(DATA_A, 4'd6, 1'b1, 1'b1, 1'b0, 32'h0, w);
    drain();
    tests++;
    if (blk_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_after_partial: blk_ready=%b, required 1", blk_ready);
    end
  endtask

  task automatic test_share_track();
    int w;
    do_ready = 1'b0;
    rdi      = 32'hA5A5A5A5;
    send_block(DATA_A, 4'd6, 1'b1, 1'b1, 1'b1, 32'h3C3C3C3C, w);
    tests++;
    if (do_data !== 32'h00112233) begin
      fails++;
      $display("[TB] FAIL share_beat0: %h, required 00112233", do_data);
    end
    do_ready = 1'b1;
    @(posedge clk);
    #1;
    do_ready = 1'b0;
    tests++;
    if (do_data !== 32'h4455A5A5) begin
      fails++;
      $display("[TB] FAIL share_fill_a5: %h, required 4455a5a5", do_data);
    end
    rdi_vary = 1'b1;
    rdi      = 32'h3C3C3C3C;
    #1;
    tests++;
    if (do_data !== 32'h44553C3C) begin
      fails++;
      $display("[TB] FAIL share_fill_3c: %h, required 44553c3c", do_data);
    end
    do_ready = 1'b1;
    drain();
    rdi_vary = 1'b0;
  endtask

  task automatic test_zero_len();
    int w;
    do_ready = 1'b1;
    send_block(DATA_B, 4'd0, 1'b1, 1'b1, 1'b0, 32'h0, w);
    tests++;
    if (do_valid !== 1'b0 || blk_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL zero_len_idle: do_valid=%b blk_ready=%b, required 0 1",
               do_valid, blk_ready);
    end
    send_block(DATA_A, 4'd4, 1'b1, 1'b1, 1'b0, 32'h0, w);
    tests++;
    if (w != 0) begin
      fails++;
      $display("[TB] FAIL zero_len_next_accept: waited %0d cycles, required 0", w);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int   w;
    logic pat [5];
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_ready = 1'b0;
    fork
      send_block(DATA_B, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0, w);
      begin
        for (int k = 0; k < 30; k++) begin
          do_ready = pat[k % 5];
          @(posedge clk);
          #1;
        end
        do_ready = 1'b1;
      end
    join
    drain();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL backpressure_count: %0d beats left, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int w;
    do_ready = 1'b1;
    send_block(DATA_B, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, w);
    @(posedge clk);
    #1;
    do_ready = 1'b0;
    tests++;
    if (do_data !== 32'h01234567) begin
      fails++;
      $display("[TB] FAIL mid_beat1: %h, required 01234567", do_data);
    end
    do_ready = 1'b1;
    @(posedge clk);
    #1;
    do_ready = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (do_valid !== 1'b0 || do_data !== 32'h0 || blk_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: valid=%b data=%h ready=%b, required 0 0 0",
               do_valid, do_data, blk_ready);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    do_ready = 1'b1;
    send_block(DATA_C, 4'd11, 1'b1, 1'b1, 1'b0, 32'h0, w);
    drain();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_full_block();
    test_partial();
    test_share_track();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
